// File: rtl/regfile_wb_buffer_pkg.sv
// Shared definitions for the register-file write-back buffer: default widths,
// the hard-zero register index and the queued write-back record.
package regfile_wb_buffer_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int R0        = 0;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_buffer_if.sv
// Datapath-side bus of the write-back buffer: write-back handshake plus
// two-operand read request and registered response.
interface regfile_wb_buffer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data_a;
  logic [DATA_W-1:0] rsp_data_b;

  modport master (
    output wb_valid, wb_addr, wb_data, rd_valid, rd_addr_a, rd_addr_b,
    input  wb_ready, rsp_valid, rsp_data_a, rsp_data_b
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data, rd_valid, rd_addr_a, rd_addr_b,
    output wb_ready, rsp_valid, rsp_data_a, rsp_data_b
  );
endinterface

// File: rtl/regfile_wb_buffer_wb_queue.sv
// Circular write-back queue with per-entry valid bits and two parallel
// address-match lookup ports returning the youngest matching entry.
module wb_queue
  import regfile_wb_buffer_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              empty,
  output logic              full,
  input  logic [ADDR_W-1:0] lk_addr_a,
  output logic              hit_a,
  output logic [DATA_W-1:0] hit_data_a,
  input  logic [ADDR_W-1:0] lk_addr_b,
  output logic              hit_b,
  output logic [DATA_W-1:0] hit_data_b
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [PTR_W-1:0]  head, tail;
  logic [PTR_W:0]    count;

  assign empty     = (count == '0);
  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign head_addr = mem_addr[head];
  assign head_data = mem_data[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      // tail never equals head on a push-while-popping when full, since push requires !full
      if (pop)  valid[head] <= 1'b0;
      if (push) valid[tail] <= 1'b1;
    end
  end

  // Payload storage carries no reset; valid bits alone qualify it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[tail] <= push_addr;
      mem_data[tail] <= push_data;
    end
  end

  // Walk oldest to youngest so the last hit overrides earlier ones.
  always_comb begin
    logic [PTR_W-1:0] idx;
    hit_a      = 1'b0;
    hit_data_a = '0;
    hit_b      = 1'b0;
    hit_data_b = '0;
    idx        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (valid[idx] && mem_addr[idx] == lk_addr_a) begin
        hit_a      = 1'b1;
        hit_data_a = mem_data[idx];
      end
      if (valid[idx] && mem_addr[idx] == lk_addr_b) begin
        hit_b      = 1'b1;
        hit_data_b = mem_data[idx];
      end
    end
  end
endmodule

// File: rtl/regfile_wb_buffer.sv
// Register-file write-back buffer: queues write-backs, drains one per cycle to
// the regfile write port and serves forwarded two-operand reads.
module regfile_wb_buffer
  import regfile_wb_buffer_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  regfile_wb_buffer_if.slave bus,
  output logic [ADDR_W-1:0] rf_addr_a,
  output logic [ADDR_W-1:0] rf_addr_b,
  input  logic [DATA_W-1:0] rf_data_a,
  input  logic [DATA_W-1:0] rf_data_b,
  input  logic              rf_wr_stall,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              idle
);
  logic              empty, full, push, wb_acc;
  logic              hit_a, hit_b;
  logic [DATA_W-1:0] hit_data_a, hit_data_b;
  logic              vld_p1;
  logic [DATA_W-1:0] rsp_a_p1, rsp_b_p1;

  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [ADDR_W-1:0] idx,
    input logic              wb_hit,
    input logic [DATA_W-1:0] wb_data,
    input logic              q_hit,
    input logic [DATA_W-1:0] q_data,
    input logic [DATA_W-1:0] rf_data
  );
    if (idx == ADDR_W'(R0)) return '0;
    if (wb_hit)             return wb_data;
    if (q_hit)              return q_data;
    return rf_data;
  endfunction

  assign bus.wb_ready = !full;
  assign wb_acc       = bus.wb_valid && bus.wb_ready;
  // r0 writes complete the handshake but are never queued
  assign push         = wb_acc && (bus.wb_addr != ADDR_W'(R0));
  assign rf_wr_en     = !empty && !rf_wr_stall;
  assign idle         = empty;
  assign rf_addr_a    = bus.rd_addr_a;
  assign rf_addr_b    = bus.rd_addr_b;

  wb_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_addr  (bus.wb_addr),
    .push_data  (bus.wb_data),
    .pop        (rf_wr_en),
    .head_addr  (rf_wr_addr),
    .head_data  (rf_wr_data),
    .empty      (empty),
    .full       (full),
    .lk_addr_a  (bus.rd_addr_a),
    .hit_a      (hit_a),
    .hit_data_a (hit_data_a),
    .lk_addr_b  (bus.rd_addr_b),
    .hit_b      (hit_b),
    .hit_data_b (hit_data_b)
  );

  // Stage p1: registered operand response
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      rsp_a_p1 <= '0;
      rsp_b_p1 <= '0;
    end else begin
      vld_p1 <= bus.rd_valid;
      if (bus.rd_valid) begin
        rsp_a_p1 <= fwd_sel(bus.rd_addr_a, wb_acc && bus.wb_addr == bus.rd_addr_a,
                            bus.wb_data, hit_a, hit_data_a, rf_data_a);
        rsp_b_p1 <= fwd_sel(bus.rd_addr_b, wb_acc && bus.wb_addr == bus.rd_addr_b,
                            bus.wb_data, hit_b, hit_data_b, rf_data_b);
      end
    end
  end

  assign bus.rsp_valid  = vld_p1;
  assign bus.rsp_data_a = rsp_a_p1;
  assign bus.rsp_data_b = rsp_b_p1;
endmodule

// File: tb/tb_regfile_wb_buffer.sv
// Directed bench for regfile_wb_buffer: reset, drain, forwarding, full/stall,
// r0 handling and reset discard.
module tb_regfile_wb_buffer;
  import regfile_wb_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rf_addr_a, rf_addr_b, rf_wr_addr;
  logic [31:0] rf_data_a, rf_data_b, rf_wr_data;
  logic        rf_wr_stall, rf_wr_en, idle;
  int          n_checks = 0;
  int          n_errors = 0;

  regfile_wb_buffer_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_wb_buffer #(.DATA_W(32), .ADDR_W(5), .DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .rf_addr_a   (rf_addr_a),
    .rf_addr_b   (rf_addr_b),
    .rf_data_a   (rf_data_a),
    .rf_data_b   (rf_data_b),
    .rf_wr_stall (rf_wr_stall),
    .rf_wr_en    (rf_wr_en),
    .rf_wr_addr  (rf_wr_addr),
    .rf_wr_data  (rf_wr_data),
    .idle        (idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.wb_valid = v;
    bus.wb_addr  = a;
    bus.wb_data  = d;
  endtask

  task automatic set_rd(input logic v, input logic [4:0] a, input logic [4:0] b);
    bus.rd_valid  = v;
    bus.rd_addr_a = a;
    bus.rd_addr_b = b;
  endtask

  wb_entry_t drain_exp [4];

  initial begin
    rst = 1'b1;
    rf_wr_stall = 1'b0;
    rf_data_a = 32'h0;
    rf_data_b = 32'h0;
    set_wb(1'b0, 5'd0, 32'h0);
    set_rd(1'b0, 5'd0, 5'd0);
    drain_exp[0] = '{addr: 5'd3, data: 32'd1};
    drain_exp[1] = '{addr: 5'd3, data: 32'd2};
    drain_exp[2] = '{addr: 5'd7, data: 32'd9};
    drain_exp[3] = '{addr: 5'd8, data: 32'h44};

    // 1: reset state
    repeat (3) tick();
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_wr_en", 32'(rf_wr_en), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_wb_ready", 32'(bus.wb_ready), 32'd1);
    chk("rst_rsp_a", bus.rsp_data_a, 32'h0);
    rst = 1'b0;
    tick();

    // 2: single write-back drains next cycle
    set_wb(1'b1, 5'd5, 32'hDEAD_BEEF);
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    #1;
    chk("t2_wr_en", 32'(rf_wr_en), 32'd1);
    chk("t2_wr_addr", 32'(rf_wr_addr), 32'd5);
    chk("t2_wr_data", rf_wr_data, 32'hDEAD_BEEF);
    chk("t2_idle_busy", 32'(idle), 32'd0);
    tick();
    chk("t2_idle", 32'(idle), 32'd1);
    chk("t2_wr_en_off", 32'(rf_wr_en), 32'd0);

    // 3: stalled queue forwards youngest entry
    rf_wr_stall = 1'b1;
    set_wb(1'b1, 5'd3, 32'd1); tick();
    set_wb(1'b1, 5'd3, 32'd2); tick();
    set_wb(1'b1, 5'd7, 32'd9); tick();
    set_wb(1'b0, 5'd0, 32'h0);
    rf_data_a = 32'hAAAA; rf_data_b = 32'hBBBB;
    set_rd(1'b1, 5'd3, 5'd7);
    #1;
    chk("t3_rf_addr_a", 32'(rf_addr_a), 32'd3);
    chk("t3_stall_wr_en", 32'(rf_wr_en), 32'd0);
    tick();
    set_rd(1'b0, 5'd0, 5'd0);
    chk("t3_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("t3_rsp_a", bus.rsp_data_a, 32'd2);
    chk("t3_rsp_b", bus.rsp_data_b, 32'd9);
    tick();
    chk("t3_rsp_valid_off", 32'(bus.rsp_valid), 32'd0);

    // 4: fill to DEPTH, 5th refused, full+stall still forwards, then ordered drain
    set_wb(1'b1, 5'd8, 32'h44); tick();
    set_wb(1'b1, 5'd10, 32'h55);
    set_rd(1'b1, 5'd8, 5'd3);
    #1;
    chk("t4_full_ready", 32'(bus.wb_ready), 32'd0);
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    set_rd(1'b0, 5'd0, 5'd0);
    chk("t4_full_rsp_a", bus.rsp_data_a, 32'h44);
    chk("t4_full_rsp_b", bus.rsp_data_b, 32'd2);
    rf_wr_stall = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_drain%0d_en", i), 32'(rf_wr_en), 32'd1);
      chk($sformatf("t4_drain%0d_addr", i), 32'(rf_wr_addr), 32'(drain_exp[i].addr));
      chk($sformatf("t4_drain%0d_data", i), rf_wr_data, drain_exp[i].data);
      tick();
    end
    chk("t4_idle", 32'(idle), 32'd1);
    chk("t4_no_r10", 32'(rf_wr_en), 32'd0);

    // 5: r0 write and r0 reads
    rf_data_a = 32'h11; rf_data_b = 32'h22;
    set_wb(1'b1, 5'd0, 32'h55);
    set_rd(1'b1, 5'd0, 5'd0);
    #1;
    chk("t5_ready", 32'(bus.wb_ready), 32'd1);
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    set_rd(1'b0, 5'd0, 5'd0);
    #1;
    chk("t5_rsp_a", bus.rsp_data_a, 32'h0);
    chk("t5_rsp_b", bus.rsp_data_b, 32'h0);
    chk("t5_idle", 32'(idle), 32'd1);
    chk("t5_wr_en", 32'(rf_wr_en), 32'd0);

    // 6: same-cycle write-back bypass vs regfile
    rf_data_a = 32'h99; rf_data_b = 32'h77;
    set_wb(1'b1, 5'd9, 32'h12);
    set_rd(1'b1, 5'd9, 5'd1);
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    set_rd(1'b0, 5'd0, 5'd0);
    #1;
    chk("t6_rsp_a", bus.rsp_data_a, 32'h12);
    chk("t6_rsp_b", bus.rsp_data_b, 32'h77);
    chk("t6_wr_addr", 32'(rf_wr_addr), 32'd9);
    tick();

    // head entry being drained still forwards
    set_wb(1'b1, 5'd4, 32'h40); tick();
    set_wb(1'b0, 5'd0, 32'h0);
    rf_data_a = 32'hEE; rf_data_b = 32'hEE;
    set_rd(1'b1, 5'd4, 5'd4);
    #1;
    chk("hd_wr_en", 32'(rf_wr_en), 32'd1);
    tick();
    set_rd(1'b0, 5'd0, 5'd0);
    chk("hd_rsp_a", bus.rsp_data_a, 32'h40);
    chk("hd_rsp_b", bus.rsp_data_b, 32'h40);
    chk("hd_idle", 32'(idle), 32'd1);

    // 7: reset discards queued writes
    rf_wr_stall = 1'b1;
    set_wb(1'b1, 5'd1, 32'h1); tick();
    set_wb(1'b1, 5'd2, 32'h2); tick();
    set_wb(1'b1, 5'd6, 32'h3); tick();
    set_wb(1'b0, 5'd0, 32'h0);
    chk("t7_busy", 32'(idle), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rf_wr_stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("t7_wr_en%0d", i), 32'(rf_wr_en), 32'd0);
      chk($sformatf("t7_idle%0d", i), 32'(idle), 32'd1);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
